// File: rtl/wb_stage.sv
// MIPS write-back stage: MEM/WB register, load-data extraction and result select.
// Define WB_RETIRE_CNT_EN to add the retired_count output and its counter.
module wb_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              wb_hold,
  input  logic              in_flush,
  input  logic              in_reg_write,
  input  logic              in_mem_to_reg,
  input  logic [2:0]        in_load_type,
  input  logic [1:0]        in_byte_off,
  input  logic [ADDR_W-1:0] in_write_reg,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_data,
  output logic              RegWriteSig,
  output logic [ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0] writeData,
  output logic              misalign
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0]  retired_count
`endif
);

  localparam logic [2:0] LT_LB  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b010;
  localparam logic [2:0] LT_LH  = 3'b011;
  localparam logic [2:0] LT_LHU = 3'b100;

  logic              v_q, v_d;
  logic              done_q, done_d;
  logic              regWrite_q, regWrite_d;
  logic              memToReg_q, memToReg_d;
  logic [2:0]        loadType_q, loadType_d;
  logic [1:0]        byteOff_q, byteOff_d;
  logic [ADDR_W-1:0] writeReg_q, writeReg_d;
  logic [DATA_W-1:0] aluResult_q, aluResult_d;
  logic [DATA_W-1:0] memData_q, memData_d;

  logic [7:0]        byteSel;
  logic [15:0]       halfSel;
  logic [DATA_W-1:0] loadData;
  logic              isHalf;
  logic              isWord;

  // On hold, the entry stays put but is marked done so it commits only once.
  always_comb begin
    v_d         = v_q;
    done_d      = v_q;
    regWrite_d  = regWrite_q;
    memToReg_d  = memToReg_q;
    loadType_d  = loadType_q;
    byteOff_d   = byteOff_q;
    writeReg_d  = writeReg_q;
    aluResult_d = aluResult_q;
    memData_d   = memData_q;
    if (!wb_hold) begin
      v_d         = in_valid & ~in_flush;
      done_d      = 1'b0;
      regWrite_d  = in_reg_write;
      memToReg_d  = in_mem_to_reg;
      loadType_d  = in_load_type;
      byteOff_d   = in_byte_off;
      writeReg_d  = in_write_reg;
      aluResult_d = in_alu_result;
      memData_d   = in_mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q         <= 1'b0;
      done_q      <= 1'b0;
      regWrite_q  <= 1'b0;
      memToReg_q  <= 1'b0;
      loadType_q  <= '0;
      byteOff_q   <= '0;
      writeReg_q  <= '0;
      aluResult_q <= '0;
      memData_q   <= '0;
    end else begin
      v_q         <= v_d;
      done_q      <= done_d;
      regWrite_q  <= regWrite_d;
      memToReg_q  <= memToReg_d;
      loadType_q  <= loadType_d;
      byteOff_q   <= byteOff_d;
      writeReg_q  <= writeReg_d;
      aluResult_q <= aluResult_d;
      memData_q   <= memData_d;
    end
  end

  // Little-endian lane select; halves use only off[1], so off[0] is ignored here.
  always_comb begin
    case (byteOff_q)
      2'd0:    byteSel = memData_q[7:0];
      2'd1:    byteSel = memData_q[15:8];
      2'd2:    byteSel = memData_q[23:16];
      default: byteSel = memData_q[31:24];
    endcase
    halfSel = byteOff_q[1] ? memData_q[31:16] : memData_q[15:0];
    case (loadType_q)
      LT_LB:   loadData = {{(DATA_W-8){byteSel[7]}}, byteSel};
      LT_LBU:  loadData = {{(DATA_W-8){1'b0}}, byteSel};
      LT_LH:   loadData = {{(DATA_W-16){halfSel[15]}}, halfSel};
      LT_LHU:  loadData = {{(DATA_W-16){1'b0}}, halfSel};
      default: loadData = memData_q;
    endcase
  end

  assign isHalf = (loadType_q == LT_LH) | (loadType_q == LT_LHU);
  assign isWord = ~isHalf & (loadType_q != LT_LB) & (loadType_q != LT_LBU);

  assign in_ready    = ~wb_hold;
  assign writeReg    = writeReg_q;
  assign writeData   = memToReg_q ? loadData : aluResult_q;
  assign misalign    = v_q & memToReg_q &
                       ((isWord & (byteOff_q != 2'd0)) | (isHalf & byteOff_q[0]));
  assign RegWriteSig = v_q & ~done_q & regWrite_q & (writeReg_q != '0) & ~misalign;

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] retiredCnt_q, retiredCnt_d;

  // Each entry retires exactly once, in its first cycle in the stage.
  always_comb begin
    retiredCnt_d = retiredCnt_q;
    if (v_q & ~done_q) retiredCnt_d = retiredCnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) retiredCnt_q <= '0;
    else     retiredCnt_q <= retiredCnt_d;
  end

  assign retired_count = retiredCnt_q;
`endif

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MIPS write-back stage: MEM/WB pipeline register plus load-data extraction and result select.
- Directly drives the register file write port: RegWriteSig, writeReg and writeData.
- Accepts one retiring instruction per cycle from MEM.
- Supports hold (stall) and flush; guarantees exactly one commit per instruction.

Parameters:
DATA_W, 32, data width (fixed at 32 for byte/half extraction)
ADDR_W, 5, register address width
CNT_W, 32, retire counter width (used only with WB_RETIRE_CNT_EN)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  MEM presents an instruction
in_ready  output  1  stage accepts this cycle; equals !wb_hold
wb_hold  input  1  freeze stage register (hazard/debug stall)
in_flush  input  1  discard the incoming instruction
in_reg_write  input  1  instruction writes a register
in_mem_to_reg  input  1  1 = load data, 0 = ALU result
in_load_type  input  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU; others = LW
in_byte_off  input  2  address[1:0] of the load
in_write_reg  input  ADDR_W  destination register
in_alu_result  input  DATA_W  ALU result
in_mem_data  input  DATA_W  aligned memory word
RegWriteSig  output  1  register file write enable
writeReg  output  ADDR_W  register file write address
writeData  output  DATA_W  register file write data
misalign  output  1  held load is misaligned
retired_count  output  CNT_W  instructions retired (WB_RETIRE_CNT_EN only)

Behaviour:
- Single clock clk; reset rst is synchronous and active-high.
- State: v, done, plus registered copies of all in_* fields.
- Reset: v=0, done=0, all field registers 0, retired_count=0.
- Resulting reset outputs: RegWriteSig=0, writeReg=0, writeData=0, misalign=0.
- Capture (edge with !rst and !wb_hold):
  - v <= in_valid & !in_flush; done <= 0; fields <= inputs.
  - Fields load even when v becomes 0.
  - in_flush has priority over in_valid.
- Hold (edge with wb_hold):
  - Fields and v are kept.
  - done <= v (the entry already committed, so no further commit).
- Latency: an input accepted at edge N drives RegWriteSig in cycle N+1.
- Outputs are combinational from the stage register:
  - writeReg = reg field.
  - writeData = mem_to_reg ? extract : alu_result.
  - RegWriteSig = v & !done & reg_write & (writeReg != 0) & !misalign.
- Register 0 is never written: RegWriteSig stays 0 even if reg_write=1.
- Extraction is little-endian; offset 0 = bits 7:0.
  - LB/LBU: byte off; sign- or zero-extended.
  - LH/LHU: half off[1]; sign- or zero-extended.
  - LW: full word.
- misalign = v & mem_to_reg & ((LW & off!=0) | ((LH|LHU) & off[0])).
  - A misaligned load suppresses the write; it still retires.
  - writeData still shows the extracted value (off[0] ignored for halves).
- Reset mid-hold: the entry is dropped, no write.
- Flush while wb_hold=1: no effect, since nothing is captured.

Optional Feature:
- WB_RETIRE_CNT_EN defined:
  - retired_count port exists.
  - Increments by 1 at each edge where v & !done & !rst, i.e. once per entry, including non-writing, misaligned and reg-0 entries.
  - Wraps modulo 2^CNT_W.
- WB_RETIRE_CNT_EN undefined:
  - Port and counter logic are absent.
  - All other behaviour is identical.

Test Plan:
- ALU result:
  - Stimulus: reset, then in_valid=1, reg_write=1, mem_to_reg=0, write_reg=20, alu_result=50.
  - Response: the next cycle shows RegWriteSig=1, writeReg=20, writeData=50.
  - Response: RegWriteSig=0 the cycle after with in_valid=0; retired_count=1.
- Load extraction:
  - Stimulus: mem_data=32'h80F0_7F81, for each (type, off).
  - LB off0 -> 32'hFFFF_FF81.
  - LBU off0 -> 32'h0000_0081.
  - LH off2 -> 32'hFFFF_80F0.
  - LHU off2 -> 32'h0000_80F0.
  - LW off0 -> 32'h80F0_7F81.
- Misalignment:
  - LW off=1 -> misalign=1, RegWriteSig=0, counter still +1.
  - LH off=3 -> misalign=1, RegWriteSig=0.
- Register 0:
  - write_reg=0, reg_write=1 -> RegWriteSig=0 for the whole entry.
- Hold:
  - Stimulus: accept reg 7, then wb_hold=1 for 3 cycles while in_valid=1 with reg 9.
  - Response: RegWriteSig=1 only in the first cycle; writeReg stays 7 throughout; in_ready=0.
  - Response: reg 9 is committed after release; counter advances by exactly 2.
- Flush and reset:
  - Stimulus: in_valid=1 with in_flush=1 -> no write, no count.
  - Stimulus: rst asserted while holding a valid entry -> all outputs 0 next cycle; retired_count=0.
